// File: rtl/dcache_nway.sv
// dcache_nway: write-back, write-allocate data cache with N-way true-LRU
// replacement, parametrised in set count, associativity and block size.
// On halt, every dirty block is written back, then the hit count is written
// to HITCNT_ADDR, and flushed is raised until halt falls.
//
// Ports:
//   CLK, nRST        clock (rising edge), synchronous active-low reset
//   halt             request to flush
//   dmemREN/dmemWEN  pipeline load/store request (load has priority)
//   dmemaddr         request byte address (bits [1:0] ignored)
//   dmemstore        store data
//   dhit             request complete; dmemload valid when dhit && dmemREN
//   flushed          flush and hit-count write complete
//   dREN/dWEN        memory read/write request
//   daddr/dstore     memory word address / write data
//   dload/dwait      memory read data / busy (transfer done on req && !dwait)
module dcache_nway #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned WORDS       = 2,
  parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int unsigned BW = $clog2(WORDS);
  localparam int unsigned IW = $clog2(SETS);
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TW = 30 - BW - IW;

  typedef enum logic [2:0] {
    IDLE, WB, FILL, MISS_HIT, FLUSH_SCAN, FLUSH_WB, SAVE_COUNT, FLUSHED
  } state_t;

  state_t state, next_state;

  logic          valid [SETS][WAYS];
  logic          dirty [SETS][WAYS];
  logic [TW-1:0] tag   [SETS][WAYS];
  logic [WW-1:0] age   [SETS][WAYS];
  logic [31:0]   data  [SETS][WAYS][WORDS];

  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [BW-1:0] req_off;
  logic          wr_req;
  logic          any_req;

  logic [WW-1:0] victim, vsel, hit_way, acc_way;
  logic          hit;
  logic [BW-1:0] wcnt;
  logic          last_beat;
  logic [IW-1:0] fset;
  logic [WW-1:0] fway;
  logic          last_entry;
  logic [31:0]   hitcnt;

  assign req_off    = dmemaddr[2 +: BW];
  assign req_idx    = dmemaddr[2 + BW +: IW];
  assign req_tag    = dmemaddr[2 + BW + IW +: TW];
  assign wr_req     = dmemWEN && !dmemREN;
  assign any_req    = dmemREN || dmemWEN;
  assign last_beat  = (wcnt == BW'(WORDS - 1));
  assign last_entry = (fset == IW'(SETS - 1)) && (fway == WW'(WAYS - 1));
  assign acc_way    = (state == MISS_HIT) ? victim : hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[req_idx][w] && (tag[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // LRU way first, then overridden by the lowest-index invalid way
  // (scanned downwards so the lowest index is assigned last).
  always_comb begin
    vsel = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (age[req_idx][w] == WW'(WAYS - 1)) vsel = WW'(w);
    end
    for (int unsigned k = 0; k < WAYS; k++) begin
      if (!valid[req_idx][WAYS - 1 - k]) vsel = WW'(WAYS - 1 - k);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (halt) next_state = FLUSH_SCAN;
        else if (any_req && !hit)
          next_state = (valid[req_idx][vsel] && dirty[req_idx][vsel]) ? WB : FILL;
      end
      WB:         if (!dwait && last_beat) next_state = FILL;
      FILL:       if (!dwait && last_beat) next_state = MISS_HIT;
      MISS_HIT:   next_state = IDLE;
      FLUSH_SCAN: begin
        if (valid[fset][fway] && dirty[fset][fway]) next_state = FLUSH_WB;
        else if (last_entry)                        next_state = SAVE_COUNT;
      end
      FLUSH_WB:   if (!dwait && last_beat) next_state = FLUSH_SCAN;
      SAVE_COUNT: if (!dwait) next_state = FLUSHED;
      FLUSHED:    if (!halt) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    flushed  = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    unique case (state)
      IDLE: begin
        if (!halt && any_req && hit) begin
          dhit = 1'b1;
          if (dmemREN) dmemload = data[req_idx][hit_way][req_off];
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {tag[req_idx][victim], req_idx, wcnt, 2'b00};
        dstore = data[req_idx][victim][wcnt];
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, wcnt, 2'b00};
      end
      MISS_HIT: begin
        dhit = 1'b1;
        if (dmemREN) dmemload = data[req_idx][victim][req_off];
      end
      FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = {tag[fset][fway], fset, wcnt, 2'b00};
        dstore = data[fset][fway][wcnt];
      end
      SAVE_COUNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hitcnt;
      end
      FLUSHED: flushed = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
          age[s][w]   <= WW'(w);
        end
      end
      hitcnt <= '0;
      wcnt   <= '0;
      fset   <= '0;
      fway   <= '0;
      victim <= '0;
    end else begin
      // Ages younger than the accessed way shift older by one.
      if (dhit) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (age[req_idx][w] < age[req_idx][acc_way])
            age[req_idx][w] <= age[req_idx][w] + 1'b1;
        end
        age[req_idx][acc_way] <= '0;
      end
      unique case (state)
        IDLE: begin
          if (!halt && any_req) begin
            if (hit) begin
              hitcnt <= hitcnt + 32'd1;
              if (wr_req) begin
                data[req_idx][hit_way][req_off] <= dmemstore;
                dirty[req_idx][hit_way]         <= 1'b1;
              end
            end else begin
              victim <= vsel;
            end
          end
        end
        WB: begin
          if (!dwait) begin
            wcnt <= wcnt + 1'b1;
            if (last_beat) dirty[req_idx][victim] <= 1'b0;
          end
        end
        FILL: begin
          if (!dwait) begin
            if (wr_req && (wcnt == req_off)) begin
              data[req_idx][victim][wcnt] <= dmemstore;
              dirty[req_idx][victim]      <= 1'b1;
            end else begin
              data[req_idx][victim][wcnt] <= dload;
            end
            wcnt <= wcnt + 1'b1;
            if (last_beat) begin
              valid[req_idx][victim] <= 1'b1;
              tag[req_idx][victim]   <= req_tag;
            end
          end
        end
        FLUSH_SCAN: begin
          if (!(valid[fset][fway] && dirty[fset][fway])) begin
            valid[fset][fway] <= 1'b0;
            if (fway == WW'(WAYS - 1)) begin
              fway <= '0;
              fset <= fset + 1'b1;
            end else begin
              fway <= fway + 1'b1;
            end
          end
        end
        FLUSH_WB: begin
          if (!dwait) begin
            wcnt <= wcnt + 1'b1;
            if (last_beat) dirty[fset][fway] <= 1'b0;
          end
        end
        FLUSHED: begin
          if (!halt) begin
            fset <= '0;
            fway <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway: a default 2-way instance and a 4-way
// instance share the stimulus; the idle one is held in reset and sel picks
// whose outputs are observed. Memory read data is a fixed address pattern.
module tb_dcache_nway;

  logic        CLK = 1'b0;
  logic        nRST, halt, dmemREN, dmemWEN, dwait, sel;
  logic [31:0] dmemaddr, dmemstore, dload;
  logic        nrst_a, nrst_b;

  logic        dhit_a, flushed_a, dREN_a, dWEN_a;
  logic [31:0] dmemload_a, daddr_a, dstore_a;
  logic        dhit_b, flushed_b, dREN_b, dWEN_b;
  logic [31:0] dmemload_b, daddr_b, dstore_b;

  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;
  xfer_t log_q[$];

  always #5 CLK = ~CLK;

  assign nrst_a = nRST & ~sel;
  assign nrst_b = nRST & sel;

  dcache_nway u_dut_a (
    .CLK(CLK), .nRST(nrst_a), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit_a), .dmemload(dmemload_a),
    .flushed(flushed_a), .dREN(dREN_a), .dWEN(dWEN_a), .daddr(daddr_a),
    .dstore(dstore_a), .dload(dload), .dwait(dwait)
  );

  dcache_nway #(.SETS(8), .WAYS(4), .WORDS(2), .HITCNT_ADDR(32'h0000_3100)) u_dut_b (
    .CLK(CLK), .nRST(nrst_b), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit_b), .dmemload(dmemload_b),
    .flushed(flushed_b), .dREN(dREN_b), .dWEN(dWEN_b), .daddr(daddr_b),
    .dstore(dstore_b), .dload(dload), .dwait(dwait)
  );

  assign dhit     = sel ? dhit_b     : dhit_a;
  assign flushed  = sel ? flushed_b  : flushed_a;
  assign dREN     = sel ? dREN_b     : dREN_a;
  assign dWEN     = sel ? dWEN_b     : dWEN_a;
  assign dmemload = sel ? dmemload_b : dmemload_a;
  assign daddr    = sel ? daddr_b    : daddr_a;
  assign dstore   = sel ? dstore_b   : dstore_a;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A00, ~a[15:0]};
  endfunction

  assign dload = pat(daddr);

  always @(negedge CLK) begin
    if ((dREN || dWEN) && !dwait) log_q.push_back({dWEN, daddr, dstore});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_xfer(input string tag, input int i, input logic we,
                            input logic [31:0] addr, input logic [31:0] data);
    if (i < log_q.size()) begin
      check({tag, ".we"},   32'(log_q[i].we), 32'(we));
      check({tag, ".addr"}, log_q[i].addr, addr);
      if (we) check({tag, ".data"}, log_q[i].data, data);
    end else begin
      check({tag, ".present"}, 32'(log_q.size()), 32'(i + 1));
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int stall,
                        output int cyc, output logic [31:0] ld, output logic got);
    log_q.delete();
    dmemREN = rd; dmemWEN = wr; dmemaddr = addr; dmemstore = data;
    dwait = (stall > 0);
    cyc = 0; ld = '0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (dhit) begin
        ld  = dmemload;
        got = 1'b1;
        break;
      end
      @(posedge CLK); #1;
      cyc++;
      dwait = (cyc < stall);
    end
    if (got) begin
      @(posedge CLK); #1;
    end
    dmemREN = 1'b0; dmemWEN = 1'b0; dwait = 1'b0;
  endtask

  // Exercises one request; for a plain miss (two beats) also checks the fill addresses.
  task automatic req_chk(input string tag, input logic rd, input logic [31:0] addr,
                         input logic [31:0] sdata, input int stall, input int exp_cyc,
                         input logic [31:0] exp_ld, input int exp_n);
    int cyc; logic [31:0] ld; logic got;
    access(rd, !rd, addr, sdata, stall, cyc, ld, got);
    check({tag, ".dhit"}, 32'(got), 32'd1);
    check({tag, ".cyc"}, 32'(cyc), 32'(exp_cyc));
    if (rd) check({tag, ".load"}, ld, exp_ld);
    check({tag, ".beats"}, 32'(log_q.size()), 32'(exp_n));
    if (exp_n == 2) begin
      check_xfer({tag, ".b0"}, 0, 1'b0, {addr[31:3], 3'b000}, '0);
      check_xfer({tag, ".b1"}, 1, 1'b0, {addr[31:3], 3'b100}, '0);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  initial begin
    logic got;
    sel = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dwait = 1'b0;
    dmemaddr = '0; dmemstore = '0; nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst.dhit", 32'(dhit), 32'd0);
    check("rst.dREN", 32'(dREN), 32'd0);
    check("rst.dWEN", 32'(dWEN), 32'd0);
    check("rst.flushed", 32'(flushed), 32'd0);
    check("rst.daddr", daddr, 32'd0);
    check("rst.dstore", dstore, 32'd0);
    @(posedge CLK); #1 nRST = 1'b1;

    // Cold load, then hit in the same block
    req_chk("t1", 1'b1, 32'h40, '0, 0, 3, pat(32'h40), 2);
    req_chk("t2", 1'b1, 32'h44, '0, 0, 0, pat(32'h44), 0);

    // Store miss allocates, merges store word, then loads hit
    req_chk("t3.st", 1'b0, 32'h4C, 32'hDEADBEEF, 0, 3, '0, 2);
    req_chk("t3.ld1", 1'b1, 32'h4C, '0, 0, 0, 32'hDEADBEEF, 0);
    req_chk("t3.ld0", 1'b1, 32'h48, '0, 0, 0, pat(32'h48), 0);

    // LRU with 2 ways in set 0
    req_chk("t4.st40", 1'b0, 32'h40, 32'h1111_1111, 0, 0, '0, 0);
    req_chk("t4.ld240", 1'b1, 32'h240, '0, 0, 3, pat(32'h240), 2);
    req_chk("t4.ld40", 1'b1, 32'h40, '0, 0, 0, 32'h1111_1111, 0);
    req_chk("t4.ld440", 1'b1, 32'h440, '0, 0, 3, pat(32'h440), 2);
    req_chk("t4.ld640", 1'b1, 32'h640, '0, 0, 5, pat(32'h640), 4);
    check_xfer("t4.wb0", 0, 1'b1, 32'h40, 32'h1111_1111);
    check_xfer("t4.wb1", 1, 1'b1, 32'h44, pat(32'h44));
    check_xfer("t4.rd0", 2, 1'b0, 32'h640, '0);
    check_xfer("t4.rd1", 3, 1'b0, 32'h644, '0);

    // Second dirty block via store miss (no hit-count change)
    req_chk("t6.st50", 1'b0, 32'h50, 32'h0000_0055, 0, 3, '0, 2);

    // Flush: two dirty blocks, hit count 5
    log_q.delete();
    halt = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (flushed) begin
        got = 1'b1;
        break;
      end
    end
    check("t6.flushed", 32'(got), 32'd1);
    check("t6.beats", 32'(log_q.size()), 32'd5);
    check_xfer("t6.wb0", 0, 1'b1, 32'h48, pat(32'h48));
    check_xfer("t6.wb1", 1, 1'b1, 32'h4C, 32'hDEADBEEF);
    check_xfer("t6.wb2", 2, 1'b1, 32'h50, 32'h0000_0055);
    check_xfer("t6.wb3", 3, 1'b1, 32'h54, pat(32'h54));
    check_xfer("t6.cnt", 4, 1'b1, 32'h0000_3100, 32'd5);
    @(negedge CLK);
    check("t6.hold", 32'(flushed), 32'd1);
    @(posedge CLK); #1 halt = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("t6.release", 32'(flushed), 32'd0);
    @(posedge CLK); #1;
    req_chk("t6.inv48", 1'b1, 32'h48, '0, 0, 3, pat(32'h48), 2);
    req_chk("t6.inv640", 1'b1, 32'h640, '0, 0, 3, pat(32'h640), 2);

    // Reset during fill beat 0
    log_q.delete();
    dmemREN = 1'b1; dmemaddr = 32'h80;
    @(negedge CLK);
    check("t7.idle_dhit", 32'(dhit), 32'd0);
    @(negedge CLK);
    check("t7.fill_dREN", 32'(dREN), 32'd1);
    check("t7.fill_addr", daddr, 32'h80);
    nRST = 1'b0;
    @(negedge CLK);
    check("t7.rst_dREN", 32'(dREN), 32'd0);
    check("t7.rst_dhit", 32'(dhit), 32'd0);
    check("t7.rst_dWEN", 32'(dWEN), 32'd0);
    @(posedge CLK); #1 nRST = 1'b1; dmemREN = 1'b0;
    req_chk("t7.miss80", 1'b1, 32'h80, '0, 0, 3, pat(32'h80), 2);
    req_chk("t7.miss48", 1'b1, 32'h48, '0, 0, 3, pat(32'h48), 2);

    // Memory stall holds the beat
    req_chk("stall", 1'b1, 32'h18, '0, 2, 4, pat(32'h18), 2);

    // 4-way LRU: A,B,C,D fill set 0, hit A, miss E evicts B
    sel = 1'b1;
    do_reset();
    req_chk("t5.A", 1'b1, 32'h040, '0, 0, 3, pat(32'h040), 2);
    req_chk("t5.B", 1'b1, 32'h240, '0, 0, 3, pat(32'h240), 2);
    req_chk("t5.C", 1'b1, 32'h440, '0, 0, 3, pat(32'h440), 2);
    req_chk("t5.D", 1'b1, 32'h640, '0, 0, 3, pat(32'h640), 2);
    req_chk("t5.hitA", 1'b1, 32'h040, '0, 0, 0, pat(32'h040), 0);
    req_chk("t5.E", 1'b1, 32'h840, '0, 0, 3, pat(32'h840), 2);
    req_chk("t5.Bgone", 1'b1, 32'h244, '0, 0, 3, pat(32'h244), 2);
    req_chk("t5.hitA2", 1'b1, 32'h044, '0, 0, 0, pat(32'h044), 0);
    req_chk("t5.hitD", 1'b1, 32'h640, '0, 0, 0, pat(32'h640), 0);
    req_chk("t5.hitE", 1'b1, 32'h844, '0, 0, 0, pat(32'h844), 0);
    req_chk("t5.Cgone", 1'b1, 32'h440, '0, 0, 3, pat(32'h440), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/dcache_nway.md
Name: dcache_nway

Overview:
Parametrised write-back, write-allocate data cache between the pipeline's data port and the memory-side cache interface. Successor to the fixed 8-set, 2-way, 2-word dcache: set count, associativity and block size are generic, with true-LRU replacement across N ways. Provides halt-triggered flush of all dirty blocks, then a hit-count write to a fixed address. Ports are flattened (no interface bundles) so the block can be instantiated per configuration.

Parameters:
SETS, 8, number of sets; power of 2, ≥2
WAYS, 2, associativity; one of 1, 2, 4, 8
WORDS, 2, 32-bit words per block; power of 2, ≥2
HITCNT_ADDR, 32'h0000_3100, word address written with the hit count at the end of a flush

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, synchronous, active-low
halt  in  1  pipeline halted; request to flush
dmemREN  in  1  load request
dmemWEN  in  1  store request
dmemaddr  in  32  request byte address; word-aligned, bits [1:0] ignored
dmemstore  in  32  store data
dhit  out  1  request complete
dmemload  out  32  load data; valid when dhit && dmemREN
flushed  out  1  flush and hit-count write complete
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory word address
dstore  out  32  memory write data
dload  in  32  memory read data; valid when !dwait
dwait  in  1  memory busy; a transfer completes on a cycle where request && !dwait

Behaviour:
- Address split: [1:0] byte, then blkoff = log2(WORDS), idx = log2(SETS), tag = remaining upper bits.
- Per way: valid, dirty, tag, WORDS data words. Per set: age field of log2(WAYS) bits per way (0 = MRU); ages are a permutation 0..WAYS-1 after reset.
- Reset: when nRST is sampled low at a clock edge:
  - state = IDLE; all valid/dirty = 0; ages = way index; hit counter = 0; word counter = 0; flush pointers = 0.
  - All outputs then read 0.
  - Reset mid-transfer drops the memory request the following cycle; partial fill is discarded.
- Outputs are combinational from state plus array contents. Every output not explicitly driven reads 0.
- IDLE:
  - Priority: halt > dmemREN > dmemWEN.
  - Hit: dhit=1 in the same cycle. Load drives dmemload from the hit word; store writes dmemstore and sets dirty. Age update applies. hitcnt += 1, wrapping mod 2^32.
  - Miss, victim selection: lowest-index invalid way; otherwise the way with age WAYS-1. The victim is latched for the rest of the miss.
  - Miss, next state: WB if the victim is valid && dirty; otherwise FILL.
- WB: WORDS beats with dWEN=1, daddr={victim tag, idx, beat, 2'b00}, dstore = victim word[beat].
  - The beat advances on !dwait. After the last beat, clear dirty and go to FILL.
- FILL: WORDS beats with dREN=1, daddr={req tag, idx, beat, 2'b00}. On !dwait, write dload into the victim word[beat].
  - Exception: if dmemWEN and beat == blkoff, write dmemstore instead and set dirty.
  - After the last beat: set valid and tag, go to MISS_HIT.
- MISS_HIT: dhit=1 for exactly 1 cycle. For loads, dmemload = filled word[blkoff]. Age update applies; hitcnt is not incremented. Next state is IDLE.
- Age update on an access to way w: every way with age < age[w] increments by 1; age[w] = 0.
- The requester holds dmemREN/dmemWEN/dmemaddr/dmemstore stable from a miss until dhit.
- FLUSH_SCAN: walks (set, way) from (0,0), way-minor. Each step is 1 cycle.
  - Dirty entry: go to FLUSH_WB, which behaves like WB using the stored tag. On completion it clears dirty and returns to FLUSH_SCAN at the same entry.
  - Clean entry: clear valid and advance.
  - After the last entry, go to SAVE_COUNT.
- SAVE_COUNT: dWEN=1, daddr=HITCNT_ADDR, dstore=hitcnt. On !dwait, go to FLUSHED.
- FLUSHED: flushed=1. When halt falls, return to IDLE and clear the flush pointers.
- A halt that drops during a flush does not abort it; the flush runs to FLUSHED.

Test Plan:
1. Defaults, load 0x40 on a cold cache, dwait low 1 cycle per beat -> dREN beats at daddr 0x40 then 0x44; one-cycle dhit with dmemload = mem[0x40]; hitcnt unchanged.
2. Repeat load 0x44 -> dhit in the same cycle with mem[0x44], no dREN, hitcnt=1.
3. Store 0xDEADBEEF to 0x44 on a cold line -> fill reads 0x40/0x44; word1 = 0xDEADBEEF and dirty; a subsequent load 0x44 hits with 0xDEADBEEF.
4. WAYS=2: dirty 0x40, load 0x240, then access 0x40, then load 0x440 -> victim is the 0x240 way (no writeback). Next, load 0x640 -> dWEN beats at 0x40/0x44 carrying dirty data, then dREN at 0x640/0x644.
5. WAYS=4: fill tags A,B,C,D in set 0, hit A, then miss E -> victim is B. Ages are a permutation after every access.
6. Halt with 2 dirty blocks and hitcnt=5 -> 4 dWEN beats to the correct addresses, then daddr=0x3100 with dstore=5, then flushed=1 until halt falls. All lines are invalid afterward.
7. nRST low during FILL beat 0 -> next cycle dREN=0 and dhit=0; the previous address then misses.
